// File: rtl/rank_chime_if.sv
// rank_chime_if: groups the chime's event inputs and audio/status outputs.
//   signal_sound_1..3 : toggle-protocol rank events (async to clk)
//   speaker           : square-wave audio drive
//   playing           : high while a tone is sounding
//   rank_playing      : rank of current tone (1..3), 0 when silent
// master = event source / listener side, slave = rank_chime itself.
interface rank_chime_if;
    logic       signal_sound_1;
    logic       signal_sound_2;
    logic       signal_sound_3;
    logic       speaker;
    logic       playing;
    logic [1:0] rank_playing;

    modport master (
        output signal_sound_1, signal_sound_2, signal_sound_3,
        input  speaker, playing, rank_playing
    );

    modport slave (
        input  signal_sound_1, signal_sound_2, signal_sound_3,
        output speaker, playing, rank_playing
    );
endinterface

// File: rtl/rank_chime.sv
// rank_chime: three-rank priority chime. Each toggle on signal_sound_N
// queues one tone of rank N. Tones play one at a time in rank order
// (1 highest), each DURATION_CYCLES long, separated by GAP_CYCLES of
// silence when more are queued. A running tone is never preempted.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : rank_chime_if.slave (event inputs, speaker/playing/rank_playing)
module rank_chime #(
    parameter int unsigned DURATION_CYCLES = 100_000_000,
    parameter int unsigned HALF_PERIOD_1   = 50_000,
    parameter int unsigned HALF_PERIOD_2   = 75_000,
    parameter int unsigned HALF_PERIOD_3   = 100_000,
    parameter int unsigned GAP_CYCLES      = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    rank_chime_if.slave  bus
);
    localparam int unsigned MAX_A = (DURATION_CYCLES > GAP_CYCLES) ? DURATION_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_B = (HALF_PERIOD_1 > HALF_PERIOD_2) ? HALF_PERIOD_1 : HALF_PERIOD_2;
    localparam int unsigned MAX_C = (MAX_B > HALF_PERIOD_3) ? MAX_B : HALF_PERIOD_3;
    localparam int unsigned MAX_P = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CW    = $clog2(MAX_P + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t        r_state;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_prev;
    logic [1:0]    r_arm;
    logic [2:0]    r_pend;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_half;
    logic          r_speaker;
    logic          r_playing;
    logic [1:0]    r_rank;

    logic [2:0]    w_sound;
    logic [2:0]    w_event;
    logic [2:0]    w_req;
    logic [2:0]    w_sel_mask;
    logic [1:0]    w_sel_rank;
    logic [CW-1:0] w_hp_last;

    assign w_sound = {bus.signal_sound_3, bus.signal_sound_2, bus.signal_sound_1};

    // Edges are masked until r_arm saturates, so an input already high at
    // reset release looks like a level, not a toggle.
    assign w_event    = (r_sync2 ^ r_prev) & {3{r_arm == 2'd3}};
    assign w_req      = r_pend | w_event;
    // Isolate lowest set bit: rank 1 wins over 2 over 3.
    assign w_sel_mask = w_req & (~w_req + 3'd1);

    always_comb begin
        w_sel_rank = 2'd0;
        if (w_req[0])      w_sel_rank = 2'd1;
        else if (w_req[1]) w_sel_rank = 2'd2;
        else if (w_req[2]) w_sel_rank = 2'd3;
    end

    always_comb begin
        w_hp_last = CW'(HALF_PERIOD_3 - 1);
        case (r_rank)
            2'd1:    w_hp_last = CW'(HALF_PERIOD_1 - 1);
            2'd2:    w_hp_last = CW'(HALF_PERIOD_2 - 1);
            default: w_hp_last = CW'(HALF_PERIOD_3 - 1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_arm   <= '0;
        end else begin
            r_sync1 <= w_sound;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pend    <= '0;
            r_cnt     <= '0;
            r_half    <= '0;
            r_speaker <= 1'b0;
            r_playing <= 1'b0;
            r_rank    <= 2'd0;
        end else begin
            r_pend <= w_req;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_state   <= S_PLAY;
                        r_pend    <= w_req & ~w_sel_mask;
                        r_cnt     <= '0;
                        r_half    <= '0;
                        r_speaker <= 1'b1;
                        r_playing <= 1'b1;
                        r_rank    <= w_sel_rank;
                    end
                end
                S_PLAY: begin
                    if (r_cnt == CW'(DURATION_CYCLES - 1)) begin
                        r_state   <= (|w_req) ? S_GAP : S_IDLE;
                        r_cnt     <= '0;
                        r_half    <= '0;
                        r_speaker <= 1'b0;
                        r_playing <= 1'b0;
                        r_rank    <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_half == w_hp_last) begin
                            r_half    <= '0;
                            r_speaker <= ~r_speaker;
                        end else begin
                            r_half <= r_half + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // Pending never clears during a gap, so w_req is nonzero here.
                    if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                        r_state   <= S_PLAY;
                        r_pend    <= w_req & ~w_sel_mask;
                        r_cnt     <= '0;
                        r_half    <= '0;
                        r_speaker <= 1'b1;
                        r_playing <= 1'b1;
                        r_rank    <= w_sel_rank;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.speaker      = r_speaker;
    assign bus.playing      = r_playing;
    assign bus.rank_playing = r_rank;
endmodule

// File: tb/tb_rank_chime.sv
module tb_rank_chime;
    localparam int DUR = 100;
    localparam int GAP = 20;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    // Expected tone schedule for the running scenario: start edge and rank.
    int   t_start[$];
    int   t_rank[$];
    int   cut;

    rank_chime_if bus ();

    rank_chime #(
        .DURATION_CYCLES(DUR),
        .HALF_PERIOD_1  (5),
        .HALF_PERIOD_2  (7),
        .HALF_PERIOD_3  (10),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hp_of(int r);
        return (r == 1) ? 5 : (r == 2) ? 7 : 10;
    endfunction

    function automatic int exp_rank(int i);
        foreach (t_start[k])
            if (i >= t_start[k] && i < t_start[k] + DUR && i < cut) return t_rank[k];
        return 0;
    endfunction

    function automatic logic exp_spk(int i);
        foreach (t_start[k])
            if (i >= t_start[k] && i < t_start[k] + DUR && i < cut)
                return (((i - t_start[k]) / hp_of(t_rank[k])) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic edge0();
        t_start.delete();
        t_rank.delete();
        cut = 1_000_000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.signal_sound_1 = 1'b0;
        bus.signal_sound_2 = 1'b0;
        bus.signal_sound_3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 3;
        if (bus.speaker !== 1'b0) begin n_fail++; $display("FAIL reset_speaker got=%b want=0", bus.speaker); end
        if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got=%b want=0", bus.playing); end
        if (bus.rank_playing !== 2'd0) begin n_fail++; $display("FAIL reset_rank got=%0d want=0", bus.rank_playing); end
        rst = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_single_rank2();
        int er;
        logic es;
        edge0();
        t_start.push_back(3); t_rank.push_back(2);
        bus.signal_sound_2 = ~bus.signal_sound_2;
        for (int i = 1; i <= 130; i++) begin
            @(posedge clk); #1;
            er = exp_rank(i); es = exp_spk(i); n_cmp += 3;
            if (bus.playing !== (er != 0)) begin n_fail++; $display("FAIL single_playing cyc=%0d got=%b want=%b", i, bus.playing, er != 0); end
            if (bus.rank_playing !== 2'(er)) begin n_fail++; $display("FAIL single_rank cyc=%0d got=%0d want=%0d", i, bus.rank_playing, er); end
            if (bus.speaker !== es) begin n_fail++; $display("FAIL single_speaker cyc=%0d got=%b want=%b", i, bus.speaker, es); end
        end
    endtask

    task automatic test_simultaneous();
        int er;
        logic es;
        edge0();
        t_start.push_back(3);   t_rank.push_back(1);
        t_start.push_back(123); t_rank.push_back(3);
        bus.signal_sound_1 = ~bus.signal_sound_1;
        bus.signal_sound_3 = ~bus.signal_sound_3;
        for (int i = 1; i <= 250; i++) begin
            @(posedge clk); #1;
            er = exp_rank(i); es = exp_spk(i); n_cmp += 3;
            if (bus.playing !== (er != 0)) begin n_fail++; $display("FAIL simul_playing cyc=%0d got=%b want=%b", i, bus.playing, er != 0); end
            if (bus.rank_playing !== 2'(er)) begin n_fail++; $display("FAIL simul_rank cyc=%0d got=%0d want=%0d", i, bus.rank_playing, er); end
            if (bus.speaker !== es) begin n_fail++; $display("FAIL simul_speaker cyc=%0d got=%b want=%b", i, bus.speaker, es); end
        end
    endtask

    task automatic test_collapse();
        int er;
        logic es;
        edge0();
        t_start.push_back(3);   t_rank.push_back(2);
        t_start.push_back(123); t_rank.push_back(1);
        bus.signal_sound_2 = ~bus.signal_sound_2;
        for (int i = 1; i <= 260; i++) begin
            @(posedge clk); #1;
            er = exp_rank(i); es = exp_spk(i); n_cmp += 3;
            if (bus.playing !== (er != 0)) begin n_fail++; $display("FAIL collapse_playing cyc=%0d got=%b want=%b", i, bus.playing, er != 0); end
            if (bus.rank_playing !== 2'(er)) begin n_fail++; $display("FAIL collapse_rank cyc=%0d got=%0d want=%0d", i, bus.rank_playing, er); end
            if (bus.speaker !== es) begin n_fail++; $display("FAIL collapse_speaker cyc=%0d got=%b want=%b", i, bus.speaker, es); end
            if (i == 20 || i == 40 || i == 60) bus.signal_sound_1 = ~bus.signal_sound_1;
        end
    endtask

    task automatic test_gap_priority();
        int er;
        logic es;
        edge0();
        t_start.push_back(3);   t_rank.push_back(2);
        t_start.push_back(123); t_rank.push_back(1);
        t_start.push_back(243); t_rank.push_back(3);
        bus.signal_sound_2 = ~bus.signal_sound_2;
        for (int i = 1; i <= 370; i++) begin
            @(posedge clk); #1;
            er = exp_rank(i); es = exp_spk(i); n_cmp += 3;
            if (bus.playing !== (er != 0)) begin n_fail++; $display("FAIL gapprio_playing cyc=%0d got=%b want=%b", i, bus.playing, er != 0); end
            if (bus.rank_playing !== 2'(er)) begin n_fail++; $display("FAIL gapprio_rank cyc=%0d got=%0d want=%0d", i, bus.rank_playing, er); end
            if (bus.speaker !== es) begin n_fail++; $display("FAIL gapprio_speaker cyc=%0d got=%b want=%b", i, bus.speaker, es); end
            if (i == 50)  bus.signal_sound_3 = ~bus.signal_sound_3;
            if (i == 105) bus.signal_sound_1 = ~bus.signal_sound_1;
        end
    endtask

    task automatic test_reset_mid_tone();
        int er;
        logic es;
        edge0();
        t_start.push_back(3); t_rank.push_back(1);
        cut = 53;
        bus.signal_sound_1 = ~bus.signal_sound_1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            er = exp_rank(i); es = exp_spk(i); n_cmp += 3;
            if (bus.playing !== (er != 0)) begin n_fail++; $display("FAIL rstmid_playing cyc=%0d got=%b want=%b", i, bus.playing, er != 0); end
            if (bus.rank_playing !== 2'(er)) begin n_fail++; $display("FAIL rstmid_rank cyc=%0d got=%0d want=%0d", i, bus.rank_playing, er); end
            if (bus.speaker !== es) begin n_fail++; $display("FAIL rstmid_speaker cyc=%0d got=%b want=%b", i, bus.speaker, es); end
            if (i == 20) bus.signal_sound_2 = ~bus.signal_sound_2;
            if (i == 52) begin
                #2 rst = 1'b1;
                bus.signal_sound_1 = 1'b1;
                #1;
                n_cmp += 3;
                if (bus.speaker !== 1'b0) begin n_fail++; $display("FAIL rstasync_speaker got=%b want=0", bus.speaker); end
                if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL rstasync_playing got=%b want=0", bus.playing); end
                if (bus.rank_playing !== 2'd0) begin n_fail++; $display("FAIL rstasync_rank got=%0d want=0", bus.rank_playing); end
            end
            if (i == 56) #2 rst = 1'b0;
        end
    endtask

    task automatic test_after_reset();
        int er;
        logic es;
        edge0();
        t_start.push_back(3); t_rank.push_back(3);
        bus.signal_sound_3 = ~bus.signal_sound_3;
        for (int i = 1; i <= 110; i++) begin
            @(posedge clk); #1;
            er = exp_rank(i); es = exp_spk(i); n_cmp += 3;
            if (bus.playing !== (er != 0)) begin n_fail++; $display("FAIL after_playing cyc=%0d got=%b want=%b", i, bus.playing, er != 0); end
            if (bus.rank_playing !== 2'(er)) begin n_fail++; $display("FAIL after_rank cyc=%0d got=%0d want=%0d", i, bus.rank_playing, er); end
            if (bus.speaker !== es) begin n_fail++; $display("FAIL after_speaker cyc=%0d got=%b want=%b", i, bus.speaker, es); end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cut    = 1_000_000;
        test_reset();
        test_single_rank2();
        test_simultaneous();
        test_collapse();
        test_gap_priority();
        test_reset_mid_tone();
        test_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
